// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared RTC register map, date-reader FSM encoding and calendar limits
package rtc_bus_pkg;
    localparam logic [7:0] RTC_ADDR_DAY   = 8'h24;
    localparam logic [7:0] RTC_ADDR_MONTH = 8'h25;
    localparam logic [7:0] RTC_ADDR_YEAR  = 8'h26;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_GAP1   = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_GAP2   = 3'd4;
    localparam logic [2:0] ST_DECODE = 3'd5;

    localparam logic [7:0] DAY_MIN   = 8'd1;
    localparam logic [7:0] DAY_MAX   = 8'd31;
    localparam logic [7:0] MONTH_MIN = 8'd1;
    localparam logic [7:0] MONTH_MAX = 8'd12;
    localparam logic [7:0] YEAR_MIN  = 8'd0;
    localparam logic [7:0] YEAR_MAX  = 8'd99;

    function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction
endpackage

// File: rtl/bcd2bin.sv
// bcd2bin: two-digit packed BCD to binary, flagging any nibble above 9
module bcd2bin (
    input  logic [7:0] bcd,
    output logic [7:0] bin,
    output logic       valid
);
    assign bin   = {4'd0, bcd[7:4]} * 8'd10 + {4'd0, bcd[3:0]};
    assign valid = (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
endmodule

// File: rtl/rtc_date_reader.sv
// rtc_date_reader: fetches day/month/year from the RTC bus, decodes BCD and range-checks it
module rtc_date_reader
    import rtc_bus_pkg::*;
#(
    parameter int         T_PULSE    = 4,
    parameter logic [7:0] ADDR_DAY   = RTC_ADDR_DAY,
    parameter logic [7:0] ADDR_MONTH = RTC_ADDR_MONTH,
    parameter logic [7:0] ADDR_YEAR  = RTC_ADDR_YEAR
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] year
);
    localparam int CW = (T_PULSE > 1) ? $clog2(T_PULSE) : 1;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] phase;
    logic [1:0]    reg_idx;
    logic [7:0]    raw_day, raw_month, raw_year;
    logic [7:0]    bin_day, bin_month, bin_year;
    logic          ok_day, ok_month, ok_year, all_ok;
    logic          phase_last, bus_state;

    assign phase_last = (phase == CW'(T_PULSE - 1));
    assign bus_state  = (state == ST_ADDR) || (state == ST_GAP1) || (state == ST_READ) || (state == ST_GAP2);

    bcd2bin u_day   (.bcd(raw_day),   .bin(bin_day),   .valid(ok_day));
    bcd2bin u_month (.bcd(raw_month), .bin(bin_month), .valid(ok_month));
    bcd2bin u_year  (.bcd(raw_year),  .bin(bin_year),  .valid(ok_year));

    assign all_ok = ok_day && ok_month && ok_year
                 && in_range(bin_day, DAY_MIN, DAY_MAX)
                 && in_range(bin_month, MONTH_MIN, MONTH_MAX)
                 && in_range(bin_year, YEAR_MIN, YEAR_MAX);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: each bus phase advances after T_PULSE cycles, three registers then decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = start ? ST_ADDR : ST_IDLE;
            ST_ADDR:   state_nxt = phase_last ? ST_GAP1 : ST_ADDR;
            ST_GAP1:   state_nxt = phase_last ? ST_READ : ST_GAP1;
            ST_READ:   state_nxt = phase_last ? ST_GAP2 : ST_READ;
            ST_GAP2:   state_nxt = phase_last ? ((reg_idx == 2'd2) ? ST_DECODE : ST_ADDR) : ST_GAP2;
            ST_DECODE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Bus strobes decoded straight from state so reset releases the bus immediately
    always_comb begin
        busy   = (state != ST_IDLE);
        cs_n   = !((state == ST_ADDR) || (state == ST_GAP1) || (state == ST_READ));
        wr_n   = (state != ST_ADDR);
        rd_n   = (state != ST_READ);
        ad_n   = (state != ST_ADDR);
        ad_oe  = (state == ST_ADDR);
        ad_out = (state != ST_ADDR) ? 8'd0 :
                 (reg_idx == 2'd0)  ? ADDR_DAY :
                 (reg_idx == 2'd1)  ? ADDR_MONTH : ADDR_YEAR;
    end

    // Phase timer, register index and raw capture on the last READ cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= '0;
            reg_idx   <= 2'd0;
            raw_day   <= 8'd0;
            raw_month <= 8'd0;
            raw_year  <= 8'd0;
        end else begin
            phase <= (bus_state && !phase_last) ? phase + CW'(1) : '0;
            if (state == ST_IDLE) reg_idx <= 2'd0;
            else if (state == ST_GAP2 && phase_last && reg_idx != 2'd2) reg_idx <= reg_idx + 2'd1;
            if (state == ST_READ && phase_last) begin
                if (reg_idx == 2'd0) raw_day   <= ad_in;
                if (reg_idx == 2'd1) raw_month <= ad_in;
                if (reg_idx == 2'd2) raw_year  <= ad_in;
            end
        end
    end

    // Completion pulse and calendar outputs, loaded only when all three values check out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done  <= 1'b0;
            err   <= 1'b0;
            day   <= 8'd1;
            month <= 8'd1;
            year  <= 8'd0;
        end else begin
            done <= (state == ST_DECODE);
            err  <= (state == ST_DECODE) && !all_ok;
            if (state == ST_DECODE && all_ok) begin
                day   <= bin_day;
                month <= bin_month;
                year  <= bin_year;
            end
        end
    end
endmodule

// File: tb/tb_rtc_date_reader.sv
// tb_rtc_date_reader: randomized date reads against a BCD/calendar reference model and RTC bus model
module tb_rtc_date_reader;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, err, cs_n, rd_n, wr_n, ad_n, ad_oe;
    logic [7:0] ad_out, day, month, year;
    logic [7:0] ad_in = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_day = 8'h01, mem_month = 8'h01, mem_year = 8'h00;
    logic [7:0] latched = 8'h00;
    logic [7:0] addr_q[$];
    logic       prev_wr_n = 1'b1;
    int         exp_day = 1, exp_month = 1, exp_year = 0;

    rtc_date_reader #(.T_PULSE(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .err(err),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n), .ad_out(ad_out), .ad_oe(ad_oe),
        .ad_in(ad_in), .day(day), .month(month), .year(year)
    );

    always #5 clk = ~clk;

    function automatic int bcd_val(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // Reference model: returns whether the triple is a legal date and updates expected outputs
    function automatic bit model(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
        bit ok;
        ok = bcd_ok(d) && bcd_ok(m) && bcd_ok(y)
          && bcd_val(d) >= 1 && bcd_val(d) <= 31
          && bcd_val(m) >= 1 && bcd_val(m) <= 12
          && bcd_val(y) <= 99;
        if (ok) begin
            exp_day = bcd_val(d);
            exp_month = bcd_val(m);
            exp_year = bcd_val(y);
        end
        return ok;
    endfunction

    // RTC chip model plus continuous strobe-rule checks
    always @(negedge clk) begin
        if (!wr_n && prev_wr_n) addr_q.push_back(ad_out);
        prev_wr_n = wr_n;
        if (!cs_n && !wr_n) latched = ad_out;
        ad_in = (latched == 8'h24) ? mem_day : (latched == 8'h25) ? mem_month :
                (latched == 8'h26) ? mem_year : 8'hEE;
        checks++;
        if (!wr_n && !rd_n) begin
            errors++;
            $display("FAIL strobe_overlap: wr_n=%b rd_n=%b, required not both 0", wr_n, rd_n);
        end
        checks++;
        if (ad_oe && ad_n) begin
            errors++;
            $display("FAIL oe_while_data: ad_oe=%b ad_n=%b, required ad_oe only with ad_n=0", ad_oe, ad_n);
        end
    end

    task automatic check_result(input string name, input bit ok, input int n);
        checks++;
        if (n != 50) begin errors++; $display("FAIL %s latency: got %0d cycles, required 50", name, n); end
        checks++;
        if (err !== !ok) begin errors++; $display("FAIL %s err: got %b, required %b", name, err, !ok); end
        checks++;
        if (day !== 8'(exp_day) || month !== 8'(exp_month) || year !== 8'(exp_year)) begin
            errors++;
            $display("FAIL %s date: got %0d/%0d/%0d, required %0d/%0d/%0d", name, day, month, year, exp_day, exp_month, exp_year);
        end
        checks++;
        if (addr_q.size() != 3 || addr_q[0] !== 8'h24 || addr_q[1] !== 8'h25 || addr_q[2] !== 8'h26) begin
            errors++;
            $display("FAIL %s addresses: got %0d entries (%p), required 24 25 26", name, addr_q.size(), addr_q);
        end
    endtask

    // Counts cycles from the start edge until done, bounded
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_read(input string name, input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
        bit ok;
        int n;
        mem_day = d; mem_month = m; mem_year = y;
        ok = model(d, m, y);
        @(negedge clk);
        addr_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise: got %b, required 1", name, busy); end
        wait_done(n);
        check_result(name, ok, n);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b, required 0", name, done); end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({cs_n, rd_n, wr_n, ad_n, ad_oe, busy, ad_out} !== {4'b1111, 2'b00, 8'h00}) begin
            errors++;
            $display("FAIL %s bus_idle: cs_n=%b rd_n=%b wr_n=%b ad_n=%b ad_oe=%b busy=%b ad_out=%h, required 1111 0 0 00",
                     name, cs_n, rd_n, wr_n, ad_n, ad_oe, busy, ad_out);
        end
        checks++;
        if (day !== 8'd1 || month !== 8'd1 || year !== 8'd0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_vals: got %0d/%0d/%0d done=%b err=%b, required 1/1/0 0 0", name, day, month, year, done, err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_idle("idle_after_reset");
    endtask

    task automatic test_valid();
        run_read("valid_31_12_16", 8'h31, 8'h12, 8'h16);
    endtask

    task automatic test_invalid();
        run_read("bad_month", 8'h15, 8'h13, 8'h16);
        run_read("bad_nibble", 8'h0A, 8'h05, 8'h20);
        run_read("zero_day", 8'h00, 8'h05, 8'h20);
        run_read("edge_01_01_00", 8'h01, 8'h01, 8'h00);
        run_read("edge_31_12_99", 8'h31, 8'h12, 8'h99);
        run_read("day_32", 8'h32, 8'h01, 8'h10);
        run_read("year_nibble", 8'h10, 8'h10, 8'h9F);
    endtask

    task automatic test_random();
        logic [7:0] v[3];
        for (int i = 0; i < 16; i++) begin
            v[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(1, 31)));
            v[1] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(1, 12)));
            v[2] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(0, 99)));
            run_read($sformatf("random_%0d", i), v[0], v[1], v[2]);
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0, first = 0;
        mem_day = 8'h07; mem_month = 8'h04; mem_year = 8'h21;
        void'(model(mem_day, mem_month, mem_year));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 130; c++) begin
            if (c == 20) start = 1'b1;
            if (c == 21) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                if (first == 0) first = c + 1;
            end
            @(negedge clk);
        end
        checks++;
        if (dones != 1 || first != 50) begin
            errors++;
            $display("FAIL start_ignored: got %0d dones first at %0d, required 1 at 50", dones, first);
        end
        checks++;
        if (day !== 8'(exp_day) || month !== 8'(exp_month) || year !== 8'(exp_year)) begin
            errors++;
            $display("FAIL start_ignored date: got %0d/%0d/%0d, required %0d/%0d/%0d", day, month, year, exp_day, exp_month, exp_year);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        mem_day = 8'h28; mem_month = 8'h02; mem_year = 8'h24;
        ok = model(mem_day, mem_month, mem_year);
        @(negedge clk);
        addr_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check_result("b2b_first", ok, n);
        mem_day = 8'h19; mem_month = 8'h11; mem_year = 8'h03;
        ok = model(mem_day, mem_month, mem_year);
        addr_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b busy: got %b, required 1", busy); end
        wait_done(n);
        check_result("b2b_second", ok, n);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        mem_day = 8'h09; mem_month = 8'h07; mem_year = 8'h45;
        @(negedge clk);
        addr_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(addr_q.size() == 2 && rd_n === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL reset_mid timeout: waited %0d cycles for month READ", n); end
        #2 reset_n = 1'b0;
        #1;
        exp_day = 1; exp_month = 1; exp_year = 0;
        check_idle("reset_mid");
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        run_read("after_reset", 8'h09, 8'h07, 8'h45);
    endtask

    initial begin
        test_reset();
        test_valid();
        test_invalid();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtc_date_reader.md
Name: rtc_date_reader

Overview:
- Read-side counterpart of the month/day/year set counters: fetches day, month and year from the RTC chip over its multiplexed address/data bus (CS/RD/WR/AD strobes, active-low).
- Converts the BCD register contents to 8-bit binary and range-checks them, then presents calendar values in the same format the set counters produce.
- Sits between the RTC bus arbiter and the display/compare logic.

Parameters:
- T_PULSE, 4: clock cycles per bus phase; minimum 1.
- ADDR_DAY, 8'h24: RTC day register address.
- ADDR_MONTH, 8'h25: RTC month register address.
- ADDR_YEAR, 8'h26: RTC year register address.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to read the date.
- busy  out  1  high while a read sequence is in progress.
- done  out  1  one-cycle pulse when the sequence completes.
- err  out  1  valid with done: high when fetched data failed the checks.
- cs_n  out  1  RTC chip select.
- rd_n  out  1  RTC read strobe.
- wr_n  out  1  RTC write strobe.
- ad_n  out  1  address/data select: 0 = address phase, 1 = data phase.
- ad_out  out  8  bus drive value.
- ad_oe  out  1  bus output enable; the tristate buffer sits at top level.
- ad_in  in  8  bus read value.
- day  out  8  binary day, 1..31.
- month  out  8  binary month, 1..12.
- year  out  8  binary year, 0..99.

Behaviour:
- Reset (async, immediate, also mid-sequence):
  - Outputs: cs_n=rd_n=wr_n=ad_n=1, ad_oe=0, ad_out=0, busy=0, done=0, err=0, day=1, month=1, year=0.
  - FSM returns to IDLE; any partial capture is discarded.
- Handshake:
  - start is sampled in IDLE only; start while busy is ignored, not queued.
  - busy rises the cycle after start is accepted.
  - busy stays high for exactly 12*T_PULSE+1 cycles.
  - done (and err) pulse for one cycle on the first cycle busy is low again.
  - day/month/year update on that same edge.
- FSM states: IDLE, ADDR, GAP1, READ, GAP2, DECODE. Each bus state lasts T_PULSE cycles, timed by a phase counter; an index reg_idx (0=day, 1=month, 2=year) selects the register.
- ADDR: cs_n=0, ad_n=0, wr_n=0, ad_oe=1, ad_out=address of reg_idx.
- GAP1: wr_n=1, ad_oe=0, cs_n=0, ad_n=1.
- READ: cs_n=0, ad_n=1, rd_n=0. ad_in is captured into the raw register for reg_idx on the last cycle of the phase.
- GAP2: all strobes high, ad_oe=0. Then:
  - reg_idx<2: increment reg_idx and go to ADDR.
  - reg_idx=2: go to DECODE.
- DECODE: one cycle.
  - BCD to binary: value = tens*10 + units, where tens = raw[7:4] and units = raw[3:0], computed in 8-bit unsigned.
  - A value is valid when every nibble is 0..9, day is 1..31, month is 1..12 and year is 0..99.
  - All three valid: outputs load, err=0.
  - Any invalid: outputs hold their previous values, err=1.
  - Next state is IDLE, with the done pulse.
- Strobe rules:
  - wr_n and rd_n are never low simultaneously.
  - ad_oe is high only in ADDR.
  - cs_n is high in IDLE, GAP2 and DECODE.
- start asserted on the same cycle as done: accepted, and a new sequence begins.
- T_PULSE=1 is legal: every phase lasts 1 cycle.

Decomposition:
- Shared package rtc_bus_pkg holds:
  - the RTC register address constants (also used by the write-side block);
  - the FSM state encoding (localparams for 6 states, 3-bit);
  - the month/day/year range limits shared with the set counters.
- One sub-module is natural: bcd2bin (combinational, 8-bit BCD in, 8-bit binary plus valid out). It is instantiated three times.

Test Plan:
- Reset, then idle, with T_PULSE=4: outputs are day=1, month=1, year=0; all strobes are high, ad_oe=0 and busy=0.
- start, with the bus model returning 8'h31/8'h12/8'h16:
  - addresses 24, 25, 26 are seen on ad_out during the wr_n pulses;
  - done appears 50 cycles after start with day=31, month=12, year=16, err=0.
- Bus returns 8'h15/8'h13/8'h16 (month 13): done with err=1; day/month/year keep their previous values (31/12/16).
- Bus returns day 8'h0A (invalid nibble): err=1, outputs unchanged.
- start pulsed again mid-sequence: ignored; exactly one done is produced, 50 cycles after the first start.
- reset_n asserted during READ of month: strobes go high immediately; after release, a new start yields a clean full sequence with correct values.
- Check across all runs: wr_n/rd_n are never low together, and ad_oe=1 only while ad_n=0.
